// File: rtl/usb_fs_pkg.sv
// Shared constants for the full-speed USB receive path: line-state encodings
// and the 4x oversampling geometry.
package usb_fs_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_e;

    localparam int OVERSAMPLE   = 4;
    localparam int SAMPLE_PHASE = 2;
    localparam int PHASE_W      = $clog2(OVERSAMPLE);

    // NRZI: no change in line level encodes a 1, a change encodes a 0.
    function automatic logic nrzi_bit(input logic [1:0] cur, input logic [1:0] prev);
        return cur == prev;
    endfunction

endpackage

// File: rtl/usb_sync_2ff.sv
// Parameterised-depth flop synchronizer for one asynchronous pin, with a
// selectable reset value so the line can idle in J.
module usb_sync_2ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    generate
        if (STAGES == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (!rst_n) ff <= RST_VAL;
                else        ff <= d;
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (!rst_n) ff <= {STAGES{RST_VAL}};
                else        ff <= {ff[STAGES-2:0], d};
            end
        end
    endgenerate

    assign q = ff[STAGES-1];

endmodule

// File: rtl/usb_fs_rx_cdr.sv
// Full-speed USB receive front end: 4x oversampled clock/data recovery,
// NRZI decode, bit unstuffing, SE0 and EOP detection.
module usb_fs_rx_cdr
    import usb_fs_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STUFF_LEN   = 6
) (
    input  logic       clk48mhz,
    input  logic       rst_n,
    input  logic       usb_dp_i,
    input  logic       usb_dn_i,
    input  logic       rx_en,
    output logic [1:0] line_state,
    output logic       se0,
    output logic       bit_valid,
    output logic       bit_data,
    output logic       stuff_err,
    output logic       eop
);

    localparam int CNT_W = $clog2(STUFF_LEN + 1);

    logic               dp_s;
    logic               dn_s;
    logic [1:0]         ls_sync;
    logic [PHASE_W-1:0] phase;
    logic [1:0]         prev_jk;
    logic [CNT_W-1:0]   ones_cnt;
    logic [1:0]         se0_cnt;
    logic               trans;
    logic               sample;
    logic               nrzi;

    logic [1:0]         nxt_prev_jk;
    logic [CNT_W-1:0]   nxt_ones;
    logic [1:0]         nxt_se0_cnt;
    logic               nxt_valid;
    logic               nxt_data;
    logic               nxt_stuff;
    logic               nxt_eop;

    usb_sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dp (
        .clk   (clk48mhz),
        .rst_n (rst_n),
        .d     (usb_dp_i),
        .q     (dp_s)
    );

    usb_sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dn (
        .clk   (clk48mhz),
        .rst_n (rst_n),
        .d     (usb_dn_i),
        .q     (dn_s)
    );

    assign ls_sync = {dn_s, dp_s};

    // A pending edge (synced pair differs from the registered state) re-centres
    // the phase and suppresses a sample that would otherwise land this cycle.
    assign trans  = ls_sync != line_state;
    assign sample = !trans && (phase == PHASE_W'(SAMPLE_PHASE));

    always_comb begin
        nxt_prev_jk = prev_jk;
        nxt_ones    = ones_cnt;
        nxt_se0_cnt = se0_cnt;
        nxt_valid   = 1'b0;
        nxt_data    = bit_data;
        nxt_stuff   = 1'b0;
        nxt_eop     = 1'b0;
        nrzi        = nrzi_bit(line_state, prev_jk);

        if (!rx_en) begin
            nxt_prev_jk = LS_J;
            nxt_ones    = '0;
            nxt_se0_cnt = '0;
        end else if (sample) begin
            case (line_state)
                LS_SE0: begin
                    if (se0_cnt != 2'd2) nxt_se0_cnt = se0_cnt + 2'd1;
                end
                LS_J, LS_K: begin
                    // One SE0 sample is enough to accept an EOP on the next J.
                    if (line_state == LS_J && se0_cnt != 2'd0) begin
                        nxt_eop     = 1'b1;
                        nxt_prev_jk = LS_J;
                        nxt_ones    = '0;
                        nxt_se0_cnt = '0;
                    end else begin
                        nxt_prev_jk = line_state;
                        nxt_se0_cnt = '0;
                        if (ones_cnt == CNT_W'(STUFF_LEN)) begin
                            nxt_stuff = nrzi;
                            nxt_ones  = '0;
                        end else begin
                            nxt_valid = 1'b1;
                            nxt_data  = nrzi;
                            nxt_ones  = nrzi ? ones_cnt + 1'b1 : '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk48mhz) begin
        if (!rst_n) begin
            line_state <= LS_J;
            phase      <= '0;
            se0        <= 1'b0;
            prev_jk    <= LS_J;
            ones_cnt   <= '0;
            se0_cnt    <= '0;
            bit_valid  <= 1'b0;
            bit_data   <= 1'b0;
            stuff_err  <= 1'b0;
            eop        <= 1'b0;
        end else begin
            line_state <= ls_sync;
            phase      <= trans ? '0 : phase + 1'b1;
            if (sample) se0 <= (line_state == LS_SE0);
            prev_jk    <= nxt_prev_jk;
            ones_cnt   <= nxt_ones;
            se0_cnt    <= nxt_se0_cnt;
            bit_valid  <= nxt_valid;
            bit_data   <= nxt_data;
            stuff_err  <= nxt_stuff;
            eop        <= nxt_eop;
        end
    end

endmodule

// File: tb/tb_usb_fs_rx_cdr.sv
// Bench for usb_fs_rx_cdr: directed symbol vectors, corner sequences and a
// randomized line stream checked against a run-length based reference model.
module tb_usb_fs_rx_cdr;
    import usb_fs_pkg::*;

    localparam int STUFF = 6;
    localparam int NRND  = 3000;

    logic       clk48mhz = 1'b0;
    logic       rst_n    = 1'b0;
    logic       usb_dp_i = 1'b1;
    logic       usb_dn_i = 1'b0;
    logic       rx_en    = 1'b0;
    logic [1:0] line_state;
    logic       se0, bit_valid, bit_data, stuff_err, eop;

    int errors = 0;
    int checks = 0;

    usb_fs_rx_cdr #(.SYNC_STAGES(2), .STUFF_LEN(STUFF)) dut (
        .clk48mhz   (clk48mhz),
        .rst_n      (rst_n),
        .usb_dp_i   (usb_dp_i),
        .usb_dn_i   (usb_dn_i),
        .rx_en      (rx_en),
        .line_state (line_state),
        .se0        (se0),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .stuff_err  (stuff_err),
        .eop        (eop)
    );

    always #10 clk48mhz = ~clk48mhz;

    // Event log: '0'/'1' decoded bits, 'S' stuff error, 'E' end of packet.
    logic  collect = 1'b0;
    string evs;
    int    eop_cnt;

    always @(negedge clk48mhz) begin
        if (collect) begin
            if (bit_valid) begin
                if (bit_data) evs = {evs, "1"};
                else          evs = {evs, "0"};
            end
            if (stuff_err) evs = {evs, "S"};
            if (eop) begin
                evs = {evs, "E"};
                eop_cnt++;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_pins(input logic [1:0] s);
        usb_dp_i = s[0];
        usb_dn_i = s[1];
    endtask

    function automatic logic [1:0] sym2ls(input byte c);
        case (c)
            "K":     return 2'b10;
            "0":     return 2'b00;
            "1":     return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // Leaves the caller 1 time unit after the last reset edge (cycle 0).
    task automatic do_reset(input logic [1:0] pin);
        @(posedge clk48mhz); #1;
        rst_n = 1'b0;
        rx_en = 1'b0;
        set_pins(pin);
        repeat (3) @(posedge clk48mhz);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        string name;
        string sym;
        int    blen;
        int    en_at;
        string exp;
    } vec_t;

    function automatic vec_t mk(input string n, input string s, input int b,
                                input int e, input string x);
        vec_t v;
        v.name = n; v.sym = s; v.blen = b; v.en_at = e; v.exp = x;
        return v;
    endfunction

    // Each symbol is held blen cycles; rx_en rises two cycles into symbol en_at,
    // which is the cycle its edge is detected, so earlier samples stay disabled.
    task automatic run_vec(input vec_t v);
        do_reset(2'b01);
        evs     = "";
        eop_cnt = 0;
        collect = 1'b1;
        for (int i = 0; i < v.sym.len(); i++) begin
            for (int c = 0; c < v.blen; c++) begin
                if (i > 0 || c > 0) begin
                    @(posedge clk48mhz); #1;
                end
                if (c == 0) set_pins(sym2ls(v.sym[i]));
                if (i == v.en_at && c == 2) rx_en = 1'b1;
            end
        end
        repeat (4) begin
            @(posedge clk48mhz); #1;
        end
        rx_en = 1'b0;
        repeat (3) @(negedge clk48mhz);
        collect = 1'b0;
        checks++;
        if (evs != v.exp) begin
            errors++;
            $display("FAIL vec_%s: got '%s' expected '%s'", v.name, evs, v.exp);
        end
    endtask

    // Reference model: line state is the pin pattern delayed 3 cycles; a bit is
    // sampled when the level has held 2 (mod 4) cycles and is not about to change.
    logic [1:0] drv   [NRND];
    bit         en_a  [NRND];
    bit         e_se0 [NRND];
    bit         e_bv  [NRND];
    bit         e_bd  [NRND];
    bit         e_se  [NRND];
    bit         e_eop [NRND];

    function automatic logic [1:0] ls_at(input int n);
        if (n < 3) return 2'b01;
        return drv[n-3];
    endfunction

    task automatic build_random();
        int         n = 0;
        int         len;
        int         r;
        logic [1:0] s;
        bit         en_cur = 1'b1;
        int         run = 0;
        logic [1:0] pjk = 2'b01;
        int         ones = 0;
        int         se0c = 0;
        bit         last_se0 = 1'b0;
        logic [1:0] cur;
        bit         b;
        while (n < NRND) begin
            r = int'($urandom_range(0, 99));
            s = (r < 44) ? 2'b01 : (r < 88) ? 2'b10 : (r < 97) ? 2'b00 : 2'b11;
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 32))
                                              : int'($urandom_range(3, 6));
            for (int k = 0; k < len && n < NRND; k++) begin
                drv[n] = s;
                n++;
            end
        end
        for (int i = 0; i < NRND; i++) begin
            if ($urandom_range(0, 199) == 0) en_cur = !en_cur;
            en_a[i]  = en_cur;
            e_se0[i] = 1'b0; e_bv[i] = 1'b0; e_bd[i] = 1'b0;
            e_se[i]  = 1'b0; e_eop[i] = 1'b0;
        end
        for (int m = 0; m < NRND - 1; m++) begin
            cur = ls_at(m);
            if (m > 0) run = (cur != ls_at(m - 1)) ? 0 : run + 1;
            if (!en_a[m]) begin
                pjk = 2'b01; ones = 0; se0c = 0;
            end
            if (run % 4 == 2 && ls_at(m + 1) == cur) begin
                last_se0 = (cur == 2'b00);
                if (en_a[m]) begin
                    if (cur == 2'b00) begin
                        se0c = (se0c < 2) ? se0c + 1 : 2;
                    end else if (cur == 2'b01 && se0c > 0) begin
                        e_eop[m+1] = 1'b1;
                        pjk = 2'b01; ones = 0; se0c = 0;
                    end else if (cur != 2'b11) begin
                        b = (cur == pjk);
                        pjk = cur;
                        se0c = 0;
                        if (ones == STUFF) begin
                            e_se[m+1] = b;
                            ones = 0;
                        end else begin
                            e_bv[m+1] = 1'b1;
                            e_bd[m+1] = b;
                            ones = b ? ones + 1 : 0;
                        end
                    end
                end
            end
            e_se0[m+1] = last_se0;
        end
    endtask

    task automatic run_random();
        do_reset(2'b01);
        for (int n = 0; n < NRND; n++) begin
            if (n > 0) begin
                @(posedge clk48mhz); #1;
            end
            set_pins(drv[n]);
            rx_en = en_a[n];
            @(negedge clk48mhz);
            chk("rnd_line_state", int'(line_state), int'(ls_at(n)));
            chk("rnd_se0",        int'(se0),        int'(e_se0[n]));
            chk("rnd_bit_valid",  int'(bit_valid),  int'(e_bv[n]));
            if (e_bv[n]) chk("rnd_bit_data", int'(bit_data), int'(e_bd[n]));
            chk("rnd_stuff_err",  int'(stuff_err),  int'(e_se[n]));
            chk("rnd_eop",        int'(eop),        int'(e_eop[n]));
            chk("rnd_onehot", int'(bit_valid) + int'(stuff_err) + int'(eop), int'(e_bv[n]) + int'(e_se[n]) + int'(e_eop[n]));
        end
        rx_en = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = mk("sync4",      "KJKJKJKK",   4, 0, "00000001");
        vecs[1] = mk("drift5",     "KJKJKJKK",   5, 0, "00000001");
        vecs[2] = mk("stuff_drop", "KKKKKKKJ",   4, 0, "0111111");
        vecs[3] = mk("stuff_err",  "KKKKKKKK",   4, 0, "0111111S");
        vecs[4] = mk("stuff_clr",  "KKKKKKKJJJ", 4, 0, "011111111");
        vecs[5] = mk("eop",        "KJK00J",     4, 0, "000E");
        vecs[6] = mk("eop_1se0",   "KJ0J",       4, 0, "00E");
        vecs[7] = mk("se1_ign",    "KK1K",       4, 0, "011");
        vecs[8] = mk("gate_mid",   "KJKJKJKK",   4, 3, "10001");

        // Reset with the pins at K: state stays J until 3 cycles after release.
        set_pins(2'b10);
        rx_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk48mhz);
            @(negedge clk48mhz);
            chk("rst_line_state", int'(line_state), 1);
            chk("rst_outputs", int'(bit_valid | stuff_err | eop | se0), 0);
        end
        rst_n = 1'b1;
        @(posedge clk48mhz); @(negedge clk48mhz);
        @(posedge clk48mhz); @(negedge clk48mhz);
        chk("rst_latency_j", int'(line_state), 1);
        @(posedge clk48mhz); @(negedge clk48mhz);
        chk("rst_latency_k", int'(line_state), 2);
        rx_en = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Disabled receiver: line_state and se0 follow the pins, no strobes.
        do_reset(2'b01);
        evs = ""; eop_cnt = 0; collect = 1'b1;
        set_pins(2'b00);
        repeat (7) @(posedge clk48mhz);
        @(negedge clk48mhz);
        chk("gate_ls_se0", int'(line_state), 0);
        chk("gate_se0_hi", int'(se0), 1);
        set_pins(2'b01);
        repeat (7) @(posedge clk48mhz);
        @(negedge clk48mhz);
        chk("gate_ls_j", int'(line_state), 1);
        chk("gate_se0_lo", int'(se0), 0);
        set_pins(2'b10);
        repeat (4) @(posedge clk48mhz);
        @(negedge clk48mhz);
        chk("gate_ls_k", int'(line_state), 2);
        collect = 1'b0;
        chk("gate_no_events", evs.len(), 0);

        // Reset after one SE0 sample: the following J must not yield an EOP.
        do_reset(2'b01);
        set_pins(2'b10);
        repeat (2) begin @(posedge clk48mhz); #1; end
        rx_en = 1'b1;
        repeat (6) begin @(posedge clk48mhz); #1; end
        set_pins(2'b00);
        repeat (6) begin @(posedge clk48mhz); #1; end
        chk("mid_se0_seen", int'(se0), 1);
        rst_n = 1'b0;
        set_pins(2'b01);
        @(posedge clk48mhz);
        @(negedge clk48mhz);
        chk("mid_rst_ls", int'(line_state), 1);
        chk("mid_rst_se0", int'(se0), 0);
        rst_n = 1'b1;
        evs = ""; eop_cnt = 0; collect = 1'b1;
        repeat (24) @(negedge clk48mhz);
        collect = 1'b0;
        chk("mid_rst_no_eop", eop_cnt, 0);
        rx_en = 1'b0;

        build_random();
        run_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
